cdb_arbiter: RTL
================

// Module: cdb_arbiter
// PURPOSE
//  Shares the CDB_WIDTH common-data-bus broadcast slots among NUM_REQ functional-unit result ports
//  (ALU, mul/div, branch, load). Each cycle it grants up to CDB_WIDTH valid requesters using a
//  round-robin pointer with starvation promotion, and registers the winners onto the CDB that feeds
//  reservation-station wakeup, PRF write and ROB completion.
// PARAMETERS
//  NUM_REQ      4   number of FU result requesters
//  CDB_WIDTH    2   number of CDB broadcast slots per cycle
//  ROB_IDX      5   ROB id width
//  PRF_IDX      6   physical register index width
//  ARF_IDX      5   architectural register index width
//  DATA_W       32  result data width
//  STARVE_LIMIT 3   consecutive denied cycles before a requester is promoted
// PORTS
//  clk          in   1                   clock, all state on rising edge
//  rst          in   1                   asynchronous, active-high reset
//  flush        in   1                   synchronous pipeline flush (mispredict)
//  req_valid    in   NUM_REQ             FU i has a completed result
//  req_ready    out  NUM_REQ             FU i granted this cycle; handshake = valid & ready
//  req_rob_id   in   NUM_REQ*ROB_IDX     per-requester ROB id
//  req_rd_phy   in   NUM_REQ*PRF_IDX     per-requester destination physical reg
//  req_rd_arch  in   NUM_REQ*ARF_IDX     per-requester destination arch reg
//  req_rd_value in   NUM_REQ*DATA_W      per-requester result value
//  cdb_valid    out  CDB_WIDTH           slot k broadcasting
//  cdb_rob_id   out  CDB_WIDTH*ROB_IDX   slot k ROB id
//  cdb_rd_phy   out  CDB_WIDTH*PRF_IDX   slot k physical dest
//  cdb_rd_arch  out  CDB_WIDTH*ARF_IDX   slot k arch dest
//  cdb_rd_value out  CDB_WIDTH*DATA_W    slot k value
// BEHAVIOUR
//  - Reset (async, any time incl. mid-grant): cdb_valid=0, all cdb_* data=0, rr_ptr=0, starve_cnt[*]=0.
//    req_ready is combinational and is 0 while rst=1. Pending results are dropped; FUs reset too.
//  - State: rr_ptr [$clog2(NUM_REQ)-1:0]; starve_cnt[i] [$clog2(STARVE_LIMIT+1)-1:0]; output regs.
//  - Selection (combinational, per cycle): scan order = indices rr_ptr, rr_ptr+1, ... mod NUM_REQ.
//    Pass 1 grants valid requesters with starve_cnt==STARVE_LIMIT in scan order; pass 2 grants
//    remaining valid requesters in scan order; stop at CDB_WIDTH grants. req_ready[i]=grant[i].
//  - FUs must not make req_valid depend on req_ready; req_ready may depend on req_valid.
//  - Slot mapping: k-th grant in selection order (pass 1 then pass 2) -> slot k; slots fill from 0,
//    unused higher slots have cdb_valid=0 and data held at 0.
//  - Latency: exactly 1 cycle; handshake in cycle T -> cdb_* visible for cycle T+1 only (no hold).
//  - rr_ptr: if >=1 grant, rr_ptr <= (index of last grant in selection order + 1) mod NUM_REQ;
//    no grant -> unchanged.
//  - starve_cnt[i]: valid & !grant -> saturating increment to STARVE_LIMIT; grant or !valid -> 0.
//  - flush=1: all req_ready=0, cdb_valid<=0 next cycle, starve_cnt<=0, rr_ptr unchanged.
//    cdb_valid already high in the flush cycle still broadcasts (consumers apply flush themselves).
//  - NUM_REQ<=CDB_WIDTH: every valid requester granted every cycle; counters never increment.
//  - Two same-rd_phy results in one cycle are not checked here (rename guarantees uniqueness).
// TESTING
//  1 Reset: assert rst mid-cycle with cdb_valid=1 -> cdb_valid=0, rr_ptr=0 immediately, no clk needed.
//  2 Round-robin: req_valid=4'b1111 for 4 cycles -> grants {0,1},{2,3},{0,1},{2,3}; slot0 carries the
//    lower-scan-order winner; cdb_rd_phy matches granted FU one cycle later.
//  3 Single req: only req_valid[2]=1, rob_id=5'd9, value=32'hDEAD_BEEF -> req_ready=4'b0100,
//    next cycle cdb_valid=2'b01, cdb_rob_id[0]=9, cdb_rd_value[0]=DEADBEEF; rr_ptr becomes 3.
//  4 Starvation: rr_ptr held by asserting req 0,1 every cycle and req 3 constantly with ptr arranged so
//    3 loses 3 cycles -> starve_cnt[3]=3, next cycle req 3 granted in slot 0 ahead of scan order.
//  5 Flush: req_valid=4'b0011 with flush=1 -> req_ready=0, next cycle cdb_valid=0, starve_cnt cleared;
//    following cycle without flush grants {0,1} normally.
//  6 Idle: req_valid=0 for 3 cycles -> cdb_valid=0, rr_ptr unchanged, starve counters stay 0.

Source files
------------

// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: grants up to CDB_WIDTH functional-unit results per
// cycle (starved requesters first, then round-robin) and registers the winners
// onto the CDB broadcast slots one cycle later.
module cdb_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int CDB_WIDTH    = 2,
  parameter int ROB_IDX      = 5,
  parameter int PRF_IDX      = 6,
  parameter int ARF_IDX      = 5,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 3
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           flush,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [NUM_REQ*ROB_IDX-1:0]     req_rob_id,
  input  logic [NUM_REQ*PRF_IDX-1:0]     req_rd_phy,
  input  logic [NUM_REQ*ARF_IDX-1:0]     req_rd_arch,
  input  logic [NUM_REQ*DATA_W-1:0]      req_rd_value,
  output logic [CDB_WIDTH-1:0]           cdb_valid,
  output logic [CDB_WIDTH*ROB_IDX-1:0]   cdb_rob_id,
  output logic [CDB_WIDTH*PRF_IDX-1:0]   cdb_rd_phy,
  output logic [CDB_WIDTH*ARF_IDX-1:0]   cdb_rd_arch,
  output logic [CDB_WIDTH*DATA_W-1:0]    cdb_rd_value
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  typedef logic [PTR_W-1:0] idx_t;

  idx_t                        rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]            starve_cnt_q [NUM_REQ];
  logic [CNT_W-1:0]            starve_cnt_d [NUM_REQ];
  logic [NUM_REQ-1:0]          grant;
  idx_t                        slot_src [CDB_WIDTH];
  logic [CDB_WIDTH-1:0]        slot_used;
  int                          n_grant;
  idx_t                        scan_idx;
  idx_t                        last_idx;

  logic [CDB_WIDTH-1:0]         cdb_valid_q, cdb_valid_d;
  logic [CDB_WIDTH*ROB_IDX-1:0] cdb_rob_q, cdb_rob_d;
  logic [CDB_WIDTH*PRF_IDX-1:0] cdb_phy_q, cdb_phy_d;
  logic [CDB_WIDTH*ARF_IDX-1:0] cdb_arch_q, cdb_arch_d;
  logic [CDB_WIDTH*DATA_W-1:0]  cdb_value_q, cdb_value_d;

  // Two-pass scan from rr_ptr: promoted (starved) requesters first, then the rest; k-th grant -> slot k
  always_comb begin
    grant     = '0;
    slot_used = '0;
    n_grant   = 0;
    last_idx  = rr_ptr_q;
    scan_idx  = '0;
    for (int k = 0; k < CDB_WIDTH; k++) slot_src[k] = '0;
    if (!rst && !flush) begin
      for (int pass = 0; pass < 2; pass++) begin
        for (int off = 0; off < NUM_REQ; off++) begin
          scan_idx = idx_t'((int'(rr_ptr_q) + off) % NUM_REQ);
          if (req_valid[scan_idx] && !grant[scan_idx] && (n_grant < CDB_WIDTH) &&
              ((pass == 1) || (starve_cnt_q[scan_idx] == CNT_MAX))) begin
            for (int k = 0; k < CDB_WIDTH; k++) begin
              if (n_grant == k) begin
                slot_src[k]  = scan_idx;
                slot_used[k] = 1'b1;
              end
            end
            grant[scan_idx] = 1'b1;
            last_idx        = scan_idx;
            n_grant         = n_grant + 1;
          end
        end
      end
    end
  end

  assign req_ready = grant;

  // Pointer moves just past the last winner; an idle or flushed cycle leaves it alone
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (n_grant != 0) rr_ptr_d = idx_t'((int'(last_idx) + 1) % NUM_REQ);
  end

  // Denied-while-valid counters saturate at the promotion threshold; grant, idle or flush clears
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_starve
      assign starve_cnt_d[gi] = (!flush && req_valid[gi] && !grant[gi])
                              ? ((starve_cnt_q[gi] == CNT_MAX) ? CNT_MAX : starve_cnt_q[gi] + 1'b1)
                              : '0;
    end
  endgenerate

  // Route each slot's winner onto the next-cycle bus; empty slots carry zeros
  always_comb begin
    cdb_valid_d = '0;
    cdb_rob_d   = '0;
    cdb_phy_d   = '0;
    cdb_arch_d  = '0;
    cdb_value_d = '0;
    for (int k = 0; k < CDB_WIDTH; k++) begin
      if (slot_used[k]) begin
        cdb_valid_d[k]                     = 1'b1;
        cdb_rob_d[k*ROB_IDX +: ROB_IDX]    = req_rob_id[slot_src[k]*ROB_IDX +: ROB_IDX];
        cdb_phy_d[k*PRF_IDX +: PRF_IDX]    = req_rd_phy[slot_src[k]*PRF_IDX +: PRF_IDX];
        cdb_arch_d[k*ARF_IDX +: ARF_IDX]   = req_rd_arch[slot_src[k]*ARF_IDX +: ARF_IDX];
        cdb_value_d[k*DATA_W +: DATA_W]    = req_rd_value[slot_src[k]*DATA_W +: DATA_W];
      end
    end
  end

  // State and broadcast registers; reset drops anything in flight immediately
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q    <= '0;
      for (int i = 0; i < NUM_REQ; i++) starve_cnt_q[i] <= '0;
      cdb_valid_q <= '0;
      cdb_rob_q   <= '0;
      cdb_phy_q   <= '0;
      cdb_arch_q  <= '0;
      cdb_value_q <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      for (int i = 0; i < NUM_REQ; i++) starve_cnt_q[i] <= starve_cnt_d[i];
      cdb_valid_q <= cdb_valid_d;
      cdb_rob_q   <= cdb_rob_d;
      cdb_phy_q   <= cdb_phy_d;
      cdb_arch_q  <= cdb_arch_d;
      cdb_value_q <= cdb_value_d;
    end
  end

  assign cdb_valid    = cdb_valid_q;
  assign cdb_rob_id   = cdb_rob_q;
  assign cdb_rd_phy   = cdb_phy_q;
  assign cdb_rd_arch  = cdb_arch_q;
  assign cdb_rd_value = cdb_value_q;

endmodule
